// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header
// Splits the first hdr_len bytes of each byte-packed AXI-Stream packet onto a
// separate header channel. The remaining payload is re-aligned so that it
// starts at the most-significant byte lane.
// Optional feature macro: AXIS_EXTRACT_SHORT_ERR_EN adds the short_err pulse
// output, which flags single-beat packets that are too short to hold a
// complete header.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [$clog2(DATA_BYTE_WD+1)-1:0]  hdr_len,
  input  logic                               valid_in,
  input  logic [DATA_WD-1:0]                 data_in,
  input  logic [DATA_BYTE_WD-1:0]            keep_in,
  input  logic                               last_in,
  output logic                               ready_in,
  output logic                               valid_header,
  output logic [DATA_WD-1:0]                 header_out,
  output logic [DATA_BYTE_WD-1:0]            keep_header,
  input  logic                               ready_header,
  output logic                               valid_out,
  output logic [DATA_WD-1:0]                 data_out,
  output logic [DATA_BYTE_WD-1:0]            keep_out,
  output logic                               last_out,
  input  logic                               ready_out
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
  ,
  output logic                               short_err
`endif
);

  localparam int N  = DATA_BYTE_WD;
  localparam int HW = $clog2(DATA_BYTE_WD + 1);

  typedef enum logic [1:0] {SOP, BODY, FLUSH} state_t;

  state_t            state;
  logic [HW-1:0]     h_reg;
  logic [DATA_WD-1:0] res_data;
  logic [N-1:0]      res_keep;

  logic [HW-1:0]      h_in;
  logic [HW-1:0]      cur_h;
  int                 lo;
  int                 hb;
  logic [N-1:0]       hdr_keep;
  logic [DATA_WD-1:0] hdr_data;
  logic [DATA_WD-1:0] shifted_data;
  logic [N-1:0]       tail_keep;
  logic [N-1:0]       hi_mask;
  logic [N-1:0]       body_keep;
  logic [DATA_WD-1:0] body_data;
  logic               has_tail;
  logic               accept;

  // Expands a byte-enable vector into a bit mask so that disabled lanes read as 0.
  function automatic logic [DATA_WD-1:0] lane_mask(input logic [N-1:0] keep);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[8*i +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

  // Byte-lane arithmetic. The residue is kept MSB-aligned (the input shifted
  // left by H lanes), so a body beat is simply the residue ORed with the top
  // H input bytes shifted down into the low lanes.
  always_comb begin
    h_in         = (hdr_len == '0 || hdr_len > HW'(N)) ? HW'(N) : hdr_len;
    cur_h        = (state == SOP) ? h_in : h_reg;
    hb           = int'(cur_h);
    lo           = N - hb;
    hdr_keep     = keep_in >> lo;
    hdr_data     = (data_in >> (8 * lo)) & lane_mask(hdr_keep);
    shifted_data = data_in << (8 * hb);
    tail_keep    = keep_in << hb;
    has_tail     = |tail_keep;
    hi_mask      = ~({N{1'b1}} >> lo);
    body_keep    = hi_mask | (keep_in >> lo);
    body_data    = (res_data | (data_in >> (8 * lo))) & lane_mask(body_keep);
  end

  // Input is accepted only when the output channel this state would write has room.
  always_comb begin
    ready_in = 1'b0;
    case (state)
      SOP:     ready_in = !valid_header || ready_header;
      BODY:    ready_in = !valid_out || ready_out;
      default: ready_in = 1'b0;
    endcase
  end

  assign accept = valid_in && ready_in;

  // Packet state machine with registered header and payload channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SOP;
      h_reg        <= '0;
      res_data     <= '0;
      res_keep     <= '0;
      valid_header <= 1'b0;
      header_out   <= '0;
      keep_header  <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      short_err    <= 1'b0;
`endif
    end else begin
      if (valid_header && ready_header) valid_header <= 1'b0;
      if (valid_out && ready_out) valid_out <= 1'b0;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      short_err <= 1'b0;
`endif
      case (state)
        SOP: begin
          if (accept) begin
            h_reg        <= h_in;
            valid_header <= 1'b1;
            header_out   <= hdr_data;
            keep_header  <= hdr_keep;
            res_data     <= shifted_data;
            res_keep     <= tail_keep;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
            short_err    <= last_in && (hdr_keep != ({N{1'b1}} >> lo));
`endif
            if (!last_in) begin
              state <= BODY;
            end else if (has_tail) begin
              state <= FLUSH;
            end
          end
        end
        BODY: begin
          if (accept) begin
            valid_out <= 1'b1;
            data_out  <= body_data;
            keep_out  <= body_keep;
            last_out  <= last_in && !has_tail;
            res_data  <= shifted_data;
            res_keep  <= tail_keep;
            if (last_in) begin
              state <= has_tail ? FLUSH : SOP;
            end
          end
        end
        FLUSH: begin
          if (!valid_out || ready_out) begin
            valid_out <= 1'b1;
            data_out  <= res_data & lane_mask(res_keep);
            keep_out  <= res_keep;
            last_out  <= 1'b1;
            state     <= SOP;
          end
        end
        default: state <= SOP;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb_axi_stream_extract_header
// Directed bench for axi_stream_extract_header with N=4. Handshaked header and
// payload beats are captured on the falling edge and compared with
// hand-computed expectations.
module tb_axi_stream_extract_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hdr_len;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_header;
  logic [31:0] header_out;
  logic [3:0]  keep_header;
  logic        ready_header;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
  logic        short_err;
  int          shortCount = 0;
`endif

  int testsRun  = 0;
  int failCount = 0;

  logic [63:0] gotHdr[$];
  logic [63:0] expHdr[$];
  logic [63:0] gotPay[$];
  logic [63:0] expPay[$];
  logic        prevStall = 1'b0;
  logic [63:0] prevPay;
  int          w;

  axi_stream_extract_header #(.DATA_WD(32), .DATA_BYTE_WD(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_len      (hdr_len),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_in     (ready_in),
    .valid_header (valid_header),
    .header_out   (header_out),
    .keep_header  (keep_header),
    .ready_header (ready_header),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_out    (ready_out)
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
    ,
    .short_err    (short_err)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Captures completed handshakes and checks that stalled payload beats hold steady
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_header && ready_header) gotHdr.push_back(64'({header_out, keep_header}));
      if (valid_out && ready_out) gotPay.push_back(64'({data_out, keep_out, last_out}));
      if (prevStall) checkOutput("pay_stable", 64'({data_out, keep_out, last_out, valid_out}), prevPay);
      prevStall = valid_out && !ready_out;
      prevPay   = 64'({data_out, keep_out, last_out, 1'b1});
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      if (short_err) begin
        shortCount++;
        checkOutput("short_err_with_hdr", 64'(valid_header), 64'd1);
      end
`endif
    end else begin
      prevStall = 1'b0;
    end
  end

  // Presents one beat and holds it until accepted; reports the number of stall cycles
  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l, output int waits);
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    valid_in = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      waits++;
      if (waits > 200) begin
        checkOutput("beat_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic expectHeader(input logic [31:0] d, input logic [3:0] k);
    expHdr.push_back(64'({d, k}));
  endtask

  task automatic expectPayload(input logic [31:0] d, input logic [3:0] k, input logic l);
    expPay.push_back(64'({d, k, l}));
  endtask

  // Waits for all expected beats (bounded), then compares captured vs expected
  task automatic drainCheck(input string tag);
    int n;
    n = 0;
    while ((gotHdr.size() < expHdr.size() || gotPay.size() < expPay.size()) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_nhdr"}, 64'(gotHdr.size()), 64'(expHdr.size()));
    checkOutput({tag, "_npay"}, 64'(gotPay.size()), 64'(expPay.size()));
    for (int i = 0; i < gotHdr.size() && i < expHdr.size(); i++)
      checkOutput({tag, "_hdr"}, gotHdr[i], expHdr[i]);
    for (int i = 0; i < gotPay.size() && i < expPay.size(); i++)
      checkOutput({tag, "_pay"}, gotPay[i], expPay[i]);
    gotHdr.delete();
    expHdr.delete();
    gotPay.delete();
    expPay.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic runScenario1(input string tag);
    int wt;
    hdr_len = 3'd3;
    expectHeader(32'h00AABBCC, 4'b0111);
    expectPayload(32'hDD112233, 4'b1111, 1'b0);
    expectPayload(32'h44556600, 4'b1110, 1'b1);
    applyStimulus(32'hAABBCCDD, 4'b1111, 1'b0, wt);
    applyStimulus(32'h11223344, 4'b1111, 1'b0, wt);
    applyStimulus(32'h55667788, 4'b1100, 1'b1, wt);
    drainCheck(tag);
  endtask

  // Directed scenarios
  initial begin
    rst_n        = 1'b0;
    hdr_len      = 3'd0;
    valid_in     = 1'b0;
    data_in      = '0;
    keep_in      = '0;
    last_in      = 1'b0;
    ready_header = 1'b1;
    ready_out    = 1'b1;
    #3;
    checkOutput("reset_hdr", 64'({valid_header, header_out, keep_header}), 64'd0);
    checkOutput("reset_pay", 64'({valid_out, data_out, keep_out, last_out}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: H=3, last beat shorter than H
    runScenario1("s1");

    // Scenario 2: H=1, last beat leaves a residue that needs a flush cycle
    hdr_len = 3'd1;
    expectHeader(32'h000000AA, 4'b0001);
    expectPayload(32'hBBCCDD11, 4'b1111, 1'b0);
    expectPayload(32'h22334400, 4'b1110, 1'b1);
    applyStimulus(32'hAABBCCDD, 4'b1111, 1'b0, w);
    applyStimulus(32'h11223344, 4'b1111, 1'b1, w);
    checkOutput("s2_flush_rdy", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("s2_after_flush_rdy", 64'(ready_in), 64'd1);
    drainCheck("s2");

    // Scenario 3: hdr_len=0 treated as H=4, then a back-to-back H=2 packet
    hdr_len = 3'd0;
    expectHeader(32'hAABBCCDD, 4'b1111);
    expectPayload(32'h11220000, 4'b1100, 1'b1);
    expectHeader(32'h00000102, 4'b0011);
    expectPayload(32'h03040500, 4'b1110, 1'b1);
    applyStimulus(32'hAABBCCDD, 4'b1111, 1'b0, w);
    applyStimulus(32'h11223344, 4'b1100, 1'b1, w);
    hdr_len = 3'd2;
    applyStimulus(32'h01020304, 4'b1111, 1'b0, w);
    checkOutput("s3_b2b_waits", 64'(w), 64'd0);
    applyStimulus(32'h05060708, 4'b1000, 1'b1, w);
    drainCheck("s3");

    // Scenario 4a: payload backpressure mid-packet
    hdr_len = 3'd3;
    expectHeader(32'h00AABBCC, 4'b0111);
    expectPayload(32'hDD112233, 4'b1111, 1'b0);
    expectPayload(32'h44556677, 4'b1111, 1'b0);
    expectPayload(32'h8899AABB, 4'b1111, 1'b0);
    expectPayload(32'hCC000000, 4'b1000, 1'b1);
    applyStimulus(32'hAABBCCDD, 4'b1111, 1'b0, w);
    applyStimulus(32'h11223344, 4'b1111, 1'b0, w);
    ready_out = 1'b0;
    fork
      applyStimulus(32'h55667788, 4'b1111, 1'b0, w);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("s4_rdy_stall", 64'(ready_in), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    applyStimulus(32'h99AABBCC, 4'b1111, 1'b1, w);
    drainCheck("s4a");

    // Scenario 4b: header backpressure stalls the next packet's first beat
    hdr_len      = 3'd4;
    ready_header = 1'b0;
    expectHeader(32'hAABBCCDD, 4'b1111);
    expectHeader(32'h11223344, 4'b1111);
    applyStimulus(32'hAABBCCDD, 4'b1111, 1'b1, w);
    fork
      applyStimulus(32'h11223344, 4'b1111, 1'b1, w);
      begin
        repeat (2) begin
          @(negedge clk);
          checkOutput("s4_hdr_stall_rdy", 64'(ready_in), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_header = 1'b1;
      end
    join
    checkOutput("s4_hdr_stall_waits", 64'(w >= 2), 64'd1);
    drainCheck("s4b");

    // Scenario 5: single beat shorter than the header
    hdr_len = 3'd3;
    expectHeader(32'h00AABB00, 4'b0110);
    applyStimulus(32'hAABBCCDD, 4'b1100, 1'b1, w);
    drainCheck("s5");
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
    checkOutput("s5_short_err", 64'(shortCount), 64'd1);
`endif

    // Scenario 6: reset during BODY, then a clean packet
    hdr_len = 3'd3;
    applyStimulus(32'hAABBCCDD, 4'b1111, 1'b0, w);
    applyStimulus(32'h11223344, 4'b1111, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_hdr", 64'({valid_header, header_out, keep_header}), 64'd0);
    checkOutput("s6_rst_pay", 64'({valid_out, data_out, keep_out, last_out}), 64'd0);
    gotHdr.delete();
    expHdr.delete();
    gotPay.delete();
    expPay.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runScenario1("s6");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
